branch_resolve_unit: RTL
========================

// Module: branch_resolve_unit
// PURPOSE
//  Generalised PC-redirect controller for the pipelined CPU: holds the ALU flag register, evaluates the branch condition
//  and computes the PC-relative target. Drives a registered redirect plus a multi-cycle flush of wrong-path stages
//  through a 3-state FSM with a ready handshake. Sits between execute and the fetch PC mux.
// PARAMETERS
//  XLEN          32  PC/address width
//  IMM_W         24  branch immediate width (signed)
//  IMM_SHIFT     2   left shift applied to sign-extended immediate (word offset)
//  FLUSH_CYCLES  2   cycles flush is asserted per taken branch (>=1)
// PORTS
//  clk        in   1       clock
//  reset      in   1       reset, asynchronous, active-high
//  stall      in   1       fetch stalled; freezes acceptance, flag update and REDIRECT exit
//  br_valid   in   1       branch instruction present in execute
//  br_ready   out  1       1 only in IDLE; branch accepted when br_valid & br_ready & !stall
//  br_link    in   1       branch-with-link (used only with BRU_LINK_EN)
//  cond       in   4       condition code (bru_pkg::cond_e)
//  flags_we   in   1       write alu_flags into flag register
//  alu_flags  in   4       {N,Z,C,V} from ALU
//  imm        in   IMM_W   signed branch offset
//  pcf        in   XLEN    PC of the branch instruction
//  pc_src     out  1       select pc_next at fetch mux
//  pc_next    out  XLEN    redirect target / registered pcf when not redirecting
//  flush      out  1       kill wrong-path instructions in fetch/decode
//  link_we    out  1       write return address to link register
//  link_addr  out  XLEN    return address
// BEHAVIOUR
//  - Reset (any time, incl. mid-redirect): state IDLE, flags 0, count 0, all outputs 0, br_ready=1 after release.
//  - Flag reg: loads alu_flags on flags_we & !stall. Condition uses the registered value (pre-update in same cycle).
//  - Cond: EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V; HI C&!Z; LS !C|Z; GE N==V; LT N!=V;
//    GT !Z&(N==V); LE Z|(N!=V); AL, 4'b1111 always true.
//  - target = pcf + (sext(imm) << IMM_SHIFT), truncated to XLEN (wraps modulo 2^XLEN, no overflow flag).
//  - IDLE: accept & cond true -> REDIRECT next edge, pc_next<=target. Accept & cond false -> stay IDLE.
//    Not redirecting: pc_next<=pcf every non-stalled cycle; pc_src=0.
//  - REDIRECT: pc_src=1, flush=1, br_ready=0. Held while stall=1. On !stall: FLUSH_CYCLES==1 -> IDLE,
//    else FLUSH with cnt=FLUSH_CYCLES-1.
//  - FLUSH: pc_src=0, flush=1, br_ready=0; cnt decrements every cycle (stall ignored); cnt==1 -> IDLE.
//  - Latency: accept at edge N -> pc_src/flush high from N+1; flush total = FLUSH_CYCLES cycles when unstalled.
//  - br_valid while br_ready=0: ignored (wrong-path), no state effect.
//  - Simultaneous flags_we and accepted branch: branch uses old flags; new flags visible to the next branch.
// CONFIGURATION
//  - BRU_LINK_EN defined: on taken accept with br_link=1, link_we=1 and link_addr=pcf+4, registered, asserted in
//    the first REDIRECT cycle only (one pulse even if stalled). Not-taken or br_link=0: link_we stays 0.
//  - BRU_LINK_EN undefined: ports remain; link_we=0 and link_addr=0 constantly; br_link ignored.
// STRUCTURE
//  - bru_pkg: cond_e enum (EQ..AL, NV=4'b1111), flag index localparams FLAG_N/Z/C/V, state_e {IDLE,REDIRECT,FLUSH}.
//  - Sub-module bru_cond_eval: combinational (cond, flags) -> cond_true. FSM, flag reg, target and link logic stay in top.
// TESTING
//  1. flags_we with alu_flags=4'b0100, then EQ branch pcf=0x100, imm=3 -> pc_src=1 next cycle, pc_next=0x10C,
//     flush high 2 cycles, br_ready low 2 cycles.
//  2. NE branch with Z=1 -> pc_src=0, flush=0, pc_next=pcf registered, br_ready stays 1.
//  3. Taken AL, pcf=0x8, imm=24'hFFFFFE -> pc_next=0x0. pcf=0xFFFFFFFC, imm=1 -> pc_next=0x0 (wrap).
//  4. Stall held 3 cycles in REDIRECT -> pc_src/pc_next held, then FLUSH_CYCLES-1 flush cycles, back to IDLE.
//     Second br_valid during flush ignored.
//  5. Same-cycle flags_we (Z=1) + EQ branch with old Z=0 -> not taken. Next EQ branch -> taken.
//  6. Assert reset while in FLUSH -> outputs 0 immediately. With BRU_LINK_EN, br_link=1 taken at pcf=0x40 ->
//     link_we one pulse, link_addr=0x44.

Source files
------------

// File: rtl/branch_resolve_unit_pkg.sv
// Shared types for the branch resolve unit: condition codes, flag bit positions and FSM states.
package bru_pkg;

  typedef enum logic [3:0] {
    EQ = 4'b0000,
    NE = 4'b0001,
    CS = 4'b0010,
    CC = 4'b0011,
    MI = 4'b0100,
    PL = 4'b0101,
    VS = 4'b0110,
    VC = 4'b0111,
    HI = 4'b1000,
    LS = 4'b1001,
    GE = 4'b1010,
    LT = 4'b1011,
    GT = 4'b1100,
    LE = 4'b1101,
    AL = 4'b1110,
    NV = 4'b1111
  } cond_e;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    FLUSH    = 2'd2
  } state_e;

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Execute-side branch request and fetch-side redirect signals of the branch resolve unit.
interface branch_resolve_unit_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned IMM_W = 24
);
  logic             stall;
  logic             br_valid;
  logic             br_ready;
  logic             br_link;
  logic [3:0]       cond;
  logic             flags_we;
  logic [3:0]       alu_flags;
  logic [IMM_W-1:0] imm;
  logic [XLEN-1:0]  pcf;
  logic             pc_src;
  logic [XLEN-1:0]  pc_next;
  logic             flush;
  logic             link_we;
  logic [XLEN-1:0]  link_addr;

  modport slave (
    input  stall, br_valid, br_link, cond, flags_we, alu_flags, imm, pcf,
    output br_ready, pc_src, pc_next, flush, link_we, link_addr
  );

  modport master (
    output stall, br_valid, br_link, cond, flags_we, alu_flags, imm, pcf,
    input  br_ready, pc_src, pc_next, flush, link_we, link_addr
  );
endinterface

// File: rtl/bru_cond_eval.sv
// Combinational branch condition evaluation from a condition code and {N,Z,C,V} flags.
module bru_cond_eval
  import bru_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_true
);
  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    cond_true = 1'b1;
    unique case (cond_e'(cond))
      EQ:      cond_true = z;
      NE:      cond_true = !z;
      CS:      cond_true = c;
      CC:      cond_true = !c;
      MI:      cond_true = n;
      PL:      cond_true = !n;
      VS:      cond_true = v;
      VC:      cond_true = !v;
      HI:      cond_true = c && !z;
      LS:      cond_true = !c || z;
      GE:      cond_true = (n == v);
      LT:      cond_true = (n != v);
      GT:      cond_true = !z && (n == v);
      LE:      cond_true = z || (n != v);
      AL, NV:  cond_true = 1'b1;
      default: cond_true = 1'b1;
    endcase
  end
endmodule

// File: rtl/branch_resolve_unit.sv
// PC-redirect controller: flag register, branch condition, target, redirect/flush FSM.
// Optional link-register write is enabled by defining BRU_LINK_EN.
module branch_resolve_unit
  import bru_pkg::*;
#(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned IMM_W        = 24,
  parameter int unsigned IMM_SHIFT    = 2,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input logic                   clk,
  input logic                   reset,
  branch_resolve_unit_if.slave  bus
);
  localparam int unsigned CntW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [3:0]        flags_q;
  logic [XLEN-1:0]   pc_next_q, pc_next_d;
  logic [XLEN-1:0]   imm_sext, target;
  logic              br_ready, accept, taken, cond_true;

  bru_cond_eval u_cond_eval (
    .cond      (bus.cond),
    .flags     (flags_q),
    .cond_true (cond_true)
  );

  assign imm_sext = {{(XLEN-IMM_W){bus.imm[IMM_W-1]}}, bus.imm};
  assign target   = bus.pcf + (imm_sext << IMM_SHIFT);

  // Gated by reset so every output reads 0 while reset is held.
  assign br_ready = (state_q == IDLE) && !reset;
  assign accept   = bus.br_valid && br_ready && !bus.stall;
  assign taken    = accept && cond_true;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pc_next_d = pc_next_q;
    unique case (state_q)
      IDLE: begin
        if (taken) begin
          state_d   = REDIRECT;
          pc_next_d = target;
        end else if (!bus.stall) begin
          pc_next_d = bus.pcf;
        end
      end
      REDIRECT: begin
        if (!bus.stall) begin
          if (FLUSH_CYCLES == 1) begin
            state_d = IDLE;
          end else begin
            state_d = FLUSH;
            cnt_d   = CntW'(FLUSH_CYCLES - 1);
          end
        end
      end
      FLUSH: begin
        // Flush drains regardless of stall; pc_next tracks pcf again.
        if (cnt_q == CntW'(1)) state_d = IDLE;
        else                   cnt_d   = cnt_q - CntW'(1);
        if (!bus.stall) pc_next_d = bus.pcf;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      flags_q   <= '0;
      pc_next_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pc_next_q <= pc_next_d;
      if (bus.flags_we && !bus.stall) flags_q <= bus.alu_flags;
    end
  end

  assign bus.br_ready = br_ready;
  assign bus.pc_src   = (state_q == REDIRECT);
  assign bus.flush    = (state_q != IDLE);
  assign bus.pc_next  = pc_next_q;

`ifdef BRU_LINK_EN
  logic            link_we_q;
  logic [XLEN-1:0] link_addr_q;

  // taken is only possible in IDLE, so the pulse lasts exactly the first REDIRECT cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      link_we_q   <= 1'b0;
      link_addr_q <= '0;
    end else begin
      link_we_q <= taken && bus.br_link;
      if (taken && bus.br_link) link_addr_q <= bus.pcf + XLEN'(4);
    end
  end

  assign bus.link_we   = link_we_q;
  assign bus.link_addr = link_addr_q;
`else
  logic unused_link;
  assign unused_link   = bus.br_link;
  assign bus.link_we   = 1'b0;
  assign bus.link_addr = '0;
`endif
endmodule
